// File: rtl/shift_add_mult_ctrl_pkg.sv
// Shared definitions for the shift-and-add multiplier: controller state
// encoding, default operand width and the resulting product width.
package mult_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int PROD_W    = 2 * WIDTH_DEF;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        CALC = 3'd2,
        SIGN = 3'd3,
        DONE = 3'd4
    } state_t;

endpackage

// File: rtl/shift_add_mult_ctrl_if.sv
// Control bundle between the multiplier sequencer and its surroundings.
// Handshake: start is a level request, sampled only when the sequencer is
// in IDLE or DONE. The operand signs are qualified by start in that same
// cycle. done is a one-cycle pulse that marks the accumulator as final.
// state is a debug view of the sequencer FSM.
interface shift_add_mult_ctrl_if;
    import mult_pkg::*;

    logic   start;
    logic   mcand_sign;
    logic   mplier_sign;
    logic   mplier_lsb;
    logic   mplier_zero;
    logic   load;
    logic   shift_en;
    logic   add_en;
    logic   negate_result;
    logic   busy;
    logic   done;
    state_t state;

    // UI/datapath side: issues requests and reports multiplier status
    modport master (
        output start, mcand_sign, mplier_sign, mplier_lsb, mplier_zero,
        input  load, shift_en, add_en, negate_result, busy, done, state
    );

    // Sequencer side
    modport slave (
        input  start, mcand_sign, mplier_sign, mplier_lsb, mplier_zero,
        output load, shift_en, add_en, negate_result, busy, done, state
    );

endinterface

// File: rtl/shift_add_mult_ctrl_step_counter.sv
// Step counter for the multiplier scan. It clears synchronously on load and
// advances once per shift. term flags the last multiplier bit position.
module shift_add_mult_ctrl_step_counter #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             term
);

    // Count shifts. The clear has priority so every operation starts at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign term = (cnt == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/shift_add_mult_ctrl.sv
// Sequencer for the shift-and-add multiplier datapath. It loads the operand
// magnitudes, scans the multiplier LSB-first and stops early once the
// remaining multiplier is zero. When the operand signs differ, it requests
// a two's-complement of the accumulator.
module shift_add_mult_ctrl
    import mult_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    shift_add_mult_ctrl_if.slave  bus
);

    localparam int CNT_W = $clog2(WIDTH);

    state_t           state;
    logic             neg_flag;
    logic             load_r;
    logic             busy_r;
    logic             negate_r;
    logic             done_r;
    logic [CNT_W-1:0] cnt;
    logic             term;
    logic             step;

    // A step is taken on every CALC cycle while multiplier bits remain
    assign step = (state == CALC) && !bus.mplier_zero;

    shift_add_mult_ctrl_step_counter #(
        .WIDTH (WIDTH)
    ) u_step_counter (
        .clk  (clk),
        .rst  (rst),
        .clr  (state == LOAD),
        .en   (step),
        .cnt  (cnt),
        .term (term)
    );

    // State register and registered Moore strobes. Outputs are set on the
    // transition into the state that owns them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            neg_flag <= 1'b0;
            load_r   <= 1'b0;
            busy_r   <= 1'b0;
            negate_r <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state    <= LOAD;
                        neg_flag <= bus.mcand_sign ^ bus.mplier_sign;
                        load_r   <= 1'b1;
                        busy_r   <= 1'b1;
                    end
                end
                LOAD: begin
                    state  <= CALC;
                    load_r <= 1'b0;
                end
                CALC: begin
                    // Either nothing left to add, or the last bit was just scanned
                    if (bus.mplier_zero || term) begin
                        state    <= SIGN;
                        negate_r <= neg_flag;
                    end
                end
                SIGN: begin
                    state    <= DONE;
                    negate_r <= 1'b0;
                    busy_r   <= 1'b0;
                    done_r   <= 1'b1;
                end
                DONE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        state    <= LOAD;
                        neg_flag <= bus.mcand_sign ^ bus.mplier_sign;
                        load_r   <= 1'b1;
                        busy_r   <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    load_r   <= 1'b0;
                    busy_r   <= 1'b0;
                    negate_r <= 1'b0;
                    done_r   <= 1'b0;
                end
            endcase
        end
    end

    // The datapath adds the pre-shift multiplicand and then shifts, so both
    // strobes follow the live multiplier status in the same cycle.
    assign bus.shift_en      = step;
    assign bus.add_en        = step && bus.mplier_lsb;
    assign bus.load          = load_r;
    assign bus.busy          = busy_r;
    assign bus.negate_result = negate_r;
    assign bus.done          = done_r;
    assign bus.state         = state;

endmodule
